// File: rtl/alu_secuencial_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states and
// the two's-complement overflow helper.
package alu_pkg;

  // Opcode encoding inherited from the combinational 4-bit ALU.
  // OP_NULA is only the reset value of the latched opcode; it is not a valid op.
  typedef enum logic [3:0] {
    OP_NULA  = 4'b0000,
    OP_SUMA  = 4'b0001,
    OP_RESTA = 4'b0010,
    OP_MULT  = 4'b0011,
    OP_DIV   = 4'b0100,
    OP_MOD   = 4'b0101,
    OP_AND   = 4'b0110,
    OP_OR    = 4'b0111,
    OP_XOR   = 4'b1000,
    OP_SHL   = 4'b1001,
    OP_SHR   = 4'b1010
  } op_e;

  // Controller states: idle/accepting, or running an iterative op.
  typedef enum logic {
    REPOSO = 1'b0,
    ITERA  = 1'b1
  } estado_e;

  // Signed overflow of A+B (resta=0) or A-B (resta=1), from sign bits only.
  function automatic logic desborde_c2(input logic sa, input logic sb,
                                       input logic sr, input logic resta);
    logic sb_ef;
    sb_ef = sb ^ resta;
    return (sa == sb_ef) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_secuencial_if.sv
// Operand/result bus between the datapath controller and the ALU.
interface alu_secuencial_if #(
  parameter int N = 4
);
  logic         inicio;
  logic [3:0]   selector;
  logic [N-1:0] entrada1;
  logic [N-1:0] entrada2;
  logic [N-1:0] resultado;
  logic         carry;
  logic         cero;
  logic         negativo;
  logic         desbordamiento;
  logic         op_invalida;
  logic         ocupado;
  logic         listo;

  // Requester side: issues operations and reads results.
  modport master (
    output inicio, selector, entrada1, entrada2,
    input  resultado, carry, cero, negativo, desbordamiento,
    input  op_invalida, ocupado, listo
  );

  // ALU side.
  modport slave (
    input  inicio, selector, entrada1, entrada2,
    output resultado, carry, cero, negativo, desbordamiento,
    output op_invalida, ocupado, listo
  );
endinterface

// File: rtl/alu_secuencial_iter_nucleo.sv
// Iterative core: shift-add multiplier and restoring divider, one step per paso.
// Outputs show the value AFTER the step being applied this cycle, so the
// controller can capture the final result on the same edge as the last step.
module alu_iter_nucleo #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           carga_i,
  input  logic           paso_i,
  input  logic           es_mult_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] producto_o,
  output logic [N-1:0]   cociente_o,
  output logic [N-1:0]   residuo_o
);

  logic           es_mult_q;
  logic [2*N-1:0] acum_q, acum_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   resto_q, resto_d;
  logic [N-1:0]   coc_q, coc_d;
  logic [N-1:0]   divisor_q;
  logic [N:0]     resto_desp;
  logic [N:0]     resto_rest;

  // One step of each algorithm, computed from the current iteration registers.
  always_comb begin
    // Shift-add: add the shifted multiplicand when the multiplier LSB is set.
    acum_d   = acum_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    // Restoring division: bring down the next dividend bit, trial-subtract.
    // With a zero divisor the trial always succeeds, giving an all-ones
    // quotient and a remainder equal to the dividend.
    resto_desp = {resto_q, coc_q[N-1]};
    resto_rest = resto_desp - {1'b0, divisor_q};
    if (resto_desp >= {1'b0, divisor_q}) begin
      resto_d = resto_rest[N-1:0];
      coc_d   = {coc_q[N-2:0], 1'b1};
    end else begin
      resto_d = resto_desp[N-1:0];
      coc_d   = {coc_q[N-2:0], 1'b0};
    end
  end

  assign producto_o = acum_d;
  assign cociente_o = coc_d;
  assign residuo_o  = resto_d;

  // Load operands on carga, otherwise advance the selected algorithm on paso.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      es_mult_q <= 1'b0;
      acum_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      resto_q   <= '0;
      coc_q     <= '0;
      divisor_q <= '0;
    end else if (carga_i) begin
      es_mult_q <= es_mult_i;
      acum_q    <= '0;
      mcand_q   <= {{N{1'b0}}, a_i};
      mplier_q  <= b_i;
      resto_q   <= '0;
      coc_q     <= a_i;
      divisor_q <= b_i;
    end else if (paso_i) begin
      if (es_mult_q) begin
        acum_q   <= acum_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
      end else begin
        resto_q <= resto_d;
        coc_q   <= coc_d;
      end
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// Registered N-bit ALU: single-cycle logic/arith/shift ops, iterative
// mult/div/modulo behind an inicio/ocupado/listo handshake.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_secuencial_if.slave  bus
);

  localparam int            CW       = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CONT_INI = CW'(N - 1);
  localparam logic [N:0]    N_LIM    = (N + 1)'(N);

  estado_e        estado_q, estado_d;
  logic [CW-1:0]  cont_q, cont_d;
  op_e            op_q, op_d;
  logic           b_cero_q, b_cero_d;
  logic [N-1:0]   res_q, res_d;
  logic           carry_q, carry_d;
  logic           cero_q, cero_d;
  logic           neg_q, neg_d;
  logic           desb_q, desb_d;
  logic           inv_q, inv_d;
  logic           listo_q, listo_d;

  logic           carga, paso, es_mult;
  logic [2*N-1:0] producto;
  logic [N-1:0]   cociente, residuo;

  logic [N-1:0]   a, b;
  logic [N:0]     suma_w, resta_w, shl_w, shr_w;
  logic [N-1:0]   r1_res;
  logic           r1_c, r1_n, r1_v, r1_inv, es_iter;
  logic [N-1:0]   it_res;

  assign a       = bus.entrada1;
  assign b       = bus.entrada2;
  assign es_mult = (bus.selector == OP_MULT);

  alu_iter_nucleo #(.N(N)) u_nucleo (
    .clk        (clk),
    .rst        (rst),
    .carga_i    (carga),
    .paso_i     (paso),
    .es_mult_i  (es_mult),
    .a_i        (a),
    .b_i        (b),
    .producto_o (producto),
    .cociente_o (cociente),
    .residuo_o  (residuo)
  );

  // Single-cycle results and flags for the opcode currently on the bus.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    suma_w  = {1'b0, a} + {1'b0, b};
    resta_w = {1'b0, a} - {1'b0, b};
    shl_w   = {1'b0, a} << b;  // bit N is the last bit shifted out
    shr_w   = {a, 1'b0} >> b;  // bit 0 is the last bit shifted out
    r1_res  = '0;
    r1_c    = 1'b0;
    r1_n    = 1'b0;
    r1_v    = 1'b0;
    r1_inv  = 1'b0;
    es_iter = 1'b0;
    case (bus.selector)
      OP_SUMA: begin
        r1_res = suma_w[N-1:0];
        r1_c   = suma_w[N];
        r1_n   = suma_w[N-1];
        r1_v   = desborde_c2(a[N-1], b[N-1], suma_w[N-1], 1'b0);
      end
      OP_RESTA: begin
        r1_res = resta_w[N-1:0];
        r1_c   = resta_w[N];
        r1_n   = resta_w[N-1];
        r1_v   = desborde_c2(a[N-1], b[N-1], resta_w[N-1], 1'b1);
      end
      OP_AND: r1_res = a & b;
      OP_OR:  r1_res = a | b;
      OP_XOR: r1_res = a ^ b;
      OP_SHL: begin
        if ({1'b0, b} < N_LIM) begin
          r1_res = shl_w[N-1:0];
          r1_c   = shl_w[N];
        end
      end
      OP_SHR: begin
        if ({1'b0, b} < N_LIM) begin
          r1_res = shr_w[N:1];
          r1_c   = shr_w[0];
        end
      end
      OP_MULT, OP_DIV, OP_MOD: es_iter = 1'b1;
      default: r1_inv = 1'b1;
    endcase
  end

  // Final iterative result selected by the latched opcode.
  always_comb begin
    case (op_q)
      OP_MULT: it_res = producto[N-1:0];
      OP_DIV:  it_res = cociente;
      default: it_res = residuo;
    endcase
  end

  // Controller: accept ops in REPOSO, step the core in ITERA, write outputs.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    op_d     = op_q;
    b_cero_d = b_cero_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cero_d   = cero_q;
    neg_d    = neg_q;
    desb_d   = desb_q;
    inv_d    = inv_q;
    listo_d  = 1'b0;
    carga    = 1'b0;
    paso     = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (bus.inicio) begin
          if (es_iter) begin
            carga    = 1'b1;
            estado_d = ITERA;
            cont_d   = CONT_INI;
            op_d     = op_e'(bus.selector);
            b_cero_d = (b == '0);
          end else begin
            res_d   = r1_res;
            carry_d = r1_c;
            cero_d  = (r1_res == '0);
            neg_d   = r1_n;
            desb_d  = r1_v;
            inv_d   = r1_inv;
            listo_d = 1'b1;
          end
        end
      end
      ITERA: begin
        paso   = 1'b1;
        cont_d = cont_q - 1'b1;
        if (cont_q == '0) begin
          estado_d = REPOSO;
          cont_d   = '0;
          listo_d  = 1'b1;
          res_d    = it_res;
          cero_d   = (it_res == '0);
          neg_d    = 1'b0;
          inv_d    = 1'b0;
          if (op_q == OP_MULT) begin
            carry_d = |producto[2*N-1:N];
            desb_d  = |producto[2*N-1:N];
          end else begin
            carry_d = 1'b0;
            desb_d  = b_cero_q;
          end
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      estado_q <= REPOSO;
      cont_q   <= '0;
      op_q     <= OP_NULA;
      b_cero_q <= 1'b0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cero_q   <= 1'b0;
      neg_q    <= 1'b0;
      desb_q   <= 1'b0;
      inv_q    <= 1'b0;
      listo_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      op_q     <= op_d;
      b_cero_q <= b_cero_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cero_q   <= cero_d;
      neg_q    <= neg_d;
      desb_q   <= desb_d;
      inv_q    <= inv_d;
      listo_q  <= listo_d;
    end
  end

  assign bus.resultado      = res_q;
  assign bus.carry          = carry_q;
  assign bus.cero           = cero_q;
  assign bus.negativo       = neg_q;
  assign bus.desbordamiento = desb_q;
  assign bus.op_invalida    = inv_q;
  assign bus.listo          = listo_q;
  assign bus.ocupado        = (estado_q == ITERA);

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial (N=4): directed cases, handshake
// corner cases and random ops against an arithmetic reference model.
module tb_alu_secuencial;

  localparam int N    = 4;
  localparam int MOD  = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_secuencial_if #(.N(N)) bus ();

  alu_secuencial #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int res;
    bit c, z, n, v, inv, iter;
  } esperado_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int con_signo(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Reference behaviour written directly from the opcode rules.
  function automatic esperado_t modelo(input int op, input int a, input int b);
    esperado_t e;
    int s;
    e = '{res: 0, c: 0, z: 0, n: 0, v: 0, inv: 0, iter: 0};
    case (op)
      1: begin
        e.res = (a + b) % MOD;  e.c = (a + b) >= MOD;
        s = con_signo(a) + con_signo(b);
        e.v = (s > HALF - 1) || (s < -HALF);  e.n = e.res >= HALF;
      end
      2: begin
        e.res = (a - b + MOD) % MOD;  e.c = a < b;
        s = con_signo(a) - con_signo(b);
        e.v = (s > HALF - 1) || (s < -HALF);  e.n = e.res >= HALF;
      end
      3: begin
        e.iter = 1;  e.res = (a * b) % MOD;  e.c = (a * b) >= MOD;  e.v = e.c;
      end
      4: begin
        e.iter = 1;
        if (b == 0) begin e.res = MOD - 1; e.v = 1; end else e.res = a / b;
      end
      5: begin
        e.iter = 1;
        if (b == 0) begin e.res = a; e.v = 1; end else e.res = a % b;
      end
      6: e.res = a & b;
      7: e.res = a | b;
      8: e.res = a ^ b;
      9: if (b < N) begin
        e.res = (a << b) % MOD;  e.c = (b == 0) ? 0 : ((a >> (N - b)) & 1);
      end
      10: if (b < N) begin
        e.res = a >> b;  e.c = (b == 0) ? 0 : ((a >> (b - 1)) & 1);
      end
      default: e.inv = 1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Issue one op, wait (bounded) for listo, check latency, busy and results.
  task automatic do_op(input string tag, input int op, input int a, input int b);
    esperado_t e;
    int  lat;
    bit  ocup_ok;
    e = modelo(op, a, b);
    @(negedge clk);
    bus.inicio   = 1'b1;
    bus.selector = 4'(op);
    bus.entrada1 = N'(a);
    bus.entrada2 = N'(b);
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    lat = 0;
    ocup_ok = 1;
    while (!bus.listo && lat < 4 * N) begin
      if (!bus.ocupado) ocup_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"},     32'(lat), e.iter ? 32'(N) : 32'd0);
    check({tag, " ocupado"}, 32'(ocup_ok), 32'd1);
    check({tag, " res"},     32'(bus.resultado), 32'(e.res));
    check({tag, " carry"},   32'(bus.carry), 32'(e.c));
    check({tag, " cero"},    32'(bus.cero), 32'(e.z));
    check({tag, " neg"},     32'(bus.negativo), 32'(e.n));
    check({tag, " desb"},    32'(bus.desbordamiento), 32'(e.v));
    check({tag, " inval"},   32'(bus.op_invalida), 32'(e.inv));
    check({tag, " idle"},    32'(bus.ocupado), 32'd0);
    @(posedge clk); #1;
    check({tag, " pulso"},   32'(bus.listo), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  vio_listo;
    bus.inicio = 1'b0; bus.selector = '0; bus.entrada1 = '0; bus.entrada2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset res",   32'(bus.resultado), 32'd0);
    check("reset flags", 32'({bus.carry, bus.cero, bus.negativo, bus.desbordamiento,
                              bus.op_invalida, bus.ocupado, bus.listo}), 32'd0);

    // Directed cases.
    do_op("suma 7+9",   1, 4'b0111, 4'b1001);
    do_op("resta 3-5",  2, 4'b0011, 4'b0101);
    do_op("resta 7-8",  2, 4'b0111, 4'b1000);
    do_op("mult 5*3",   3, 4'b0101, 4'b0011);
    do_op("mult 6*3",   3, 4'b0110, 4'b0011);
    do_op("div 13/4",   4, 4'b1101, 4'b0100);
    do_op("mod 13/4",   5, 4'b1101, 4'b0100);
    do_op("div 13/0",   4, 4'b1101, 4'b0000);
    do_op("mod 13/0",   5, 4'b1101, 4'b0000);
    do_op("shl 11<<1",  9, 4'b1011, 4'd1);
    do_op("shr 11>>4", 10, 4'b1011, 4'd4);
    do_op("op 1111",   15, 4'b0110, 4'b0011);
    do_op("and valid",  6, 4'b1100, 4'b1010);

    // Back-to-back single-cycle ops: accepted on consecutive edges.
    @(negedge clk);
    bus.inicio = 1'b1; bus.selector = 4'd1; bus.entrada1 = 4'd1; bus.entrada2 = 4'd2;
    @(posedge clk); #1;
    check("b2b listo1", 32'(bus.listo), 32'd1);
    check("b2b res1",   32'(bus.resultado), 32'd3);
    bus.selector = 4'd6; bus.entrada1 = 4'hF; bus.entrada2 = 4'h5;
    @(posedge clk); #1;
    check("b2b listo2", 32'(bus.listo), 32'd1);
    check("b2b res2",   32'(bus.resultado), 32'd5);
    bus.inicio = 1'b0;

    // inicio during ITERA is ignored.
    @(negedge clk);
    bus.inicio = 1'b1; bus.selector = 4'd3; bus.entrada1 = 4'b0101; bus.entrada2 = 4'b0011;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    @(posedge clk); #1;
    bus.inicio = 1'b1; bus.selector = 4'd1; bus.entrada1 = 4'b0111; bus.entrada2 = 4'b1001;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    check("ign no listo", 32'(bus.listo), 32'd0);
    lat = 2;
    while (!bus.listo && lat < 4 * N) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign lat",   32'(lat), 32'(N));
    check("ign res",   32'(bus.resultado), 32'b1111);
    check("ign carry", 32'(bus.carry), 32'd0);
    @(posedge clk); #1;
    check("ign no queue", 32'(bus.listo), 32'd0);

    // Reset in the middle of a mult: outputs clear, no listo afterwards.
    @(negedge clk);
    bus.inicio = 1'b1; bus.selector = 4'd3; bus.entrada1 = 4'b0110; bus.entrada2 = 4'b0011;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst res",   32'(bus.resultado), 32'd0);
    check("rst flags", 32'({bus.carry, bus.cero, bus.negativo, bus.desbordamiento,
                            bus.op_invalida, bus.ocupado, bus.listo}), 32'd0);
    @(negedge clk) rst = 1'b0;
    vio_listo = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      if (bus.listo || bus.ocupado) vio_listo = 1;
    end
    check("rst no listo", 32'(vio_listo), 32'd0);
    do_op("suma post-rst", 1, 4'b0011, 4'b0100);

    // Random ops against the model.
    for (int i = 0; i < 150; i++) begin
      int op, a, b;
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, MOD - 1);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MOD - 1);
      do_op($sformatf("rnd%0d op%0d %0h,%0h", i, op, a, b), op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
